// File: rtl/mp_register_file_m_pkg.sv
// Shared register-file types and constants for the core's operand datapath.
// The types are sized for the default core configuration (32 x 32-bit).
package mp_register_file_m_pkg;

  localparam int RF_DATA_WIDTH = 32;
  localparam int RF_NUM_REGS   = 32;
  localparam int RF_IDX_W      = $clog2(RF_NUM_REGS);

  typedef logic [RF_IDX_W-1:0]      reg_index_t;
  typedef logic [RF_DATA_WIDTH-1:0] reg_data_t;

  localparam reg_index_t REG_ZERO     = '0;
  localparam reg_data_t  REG_ZERO_VAL = '0;

  // One writeback port; packed so arrays of ports stay packed.
  typedef struct packed {
    reg_index_t addr;
    reg_data_t  data;
    logic       en;
  } rf_wr_port_t;

endpackage

// File: rtl/mp_register_file_m_rf_scoreboard.sv
// Per-register pending scoreboard: flush beats alloc, alloc beats writeback.
// Exposes next-state pending so read_ready can bypass the same-cycle update.
module rf_scoreboard_m
  import mp_register_file_m_pkg::*;
#(
  parameter int NUM_REGS    = 32,
  parameter int IDX_W       = $clog2(NUM_REGS),
  parameter int ZERO_REG_EN = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_alloc_valid,
  input  logic [IDX_W-1:0]    i_alloc_addr,
  input  logic                i_flush,
  input  logic [NUM_REGS-1:0] i_wr_hit,
  output logic [NUM_REGS-1:0] o_pending,
  output logic [NUM_REGS-1:0] o_pending_nxt
);

  logic [NUM_REGS-1:0] r_pending;
  logic [NUM_REGS-1:0] w_pending_nxt;

  always_comb begin
    w_pending_nxt = r_pending;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (i_flush) begin
        w_pending_nxt[i] = 1'b0;
      end else if (i_alloc_valid && (i_alloc_addr == IDX_W'(i))) begin
        w_pending_nxt[i] = 1'b1;
      end else if (i_wr_hit[i]) begin
        w_pending_nxt[i] = 1'b0;
      end
    end
    // The zero register never has a producer in flight.
    if (ZERO_REG_EN != 0) begin
      w_pending_nxt[IDX_W'(REG_ZERO)] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_nxt;
    end
  end

  assign o_pending     = r_pending;
  assign o_pending_nxt = w_pending_nxt;

endmodule

// File: rtl/mp_register_file_m.sv
// Multi-port register file with write-to-read bypass, optional hardwired zero
// register and an integrated pending scoreboard; one-cycle registered reads.
module mp_register_file_m
  import mp_register_file_m_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int NUM_REGS        = 32,
  parameter int NUM_READ_PORTS  = 2,
  parameter int NUM_WRITE_PORTS = 1,
  parameter int ZERO_REG_EN     = 1,
  parameter int IDX_W           = $clog2(NUM_REGS)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_READ_PORTS*IDX_W-1:0]       read_reg_addr,
  output logic [NUM_READ_PORTS*DATA_WIDTH-1:0]  read_data,
  output logic [NUM_READ_PORTS-1:0]             read_ready,
  input  logic [NUM_WRITE_PORTS*IDX_W-1:0]      write_reg_addr,
  input  logic [NUM_WRITE_PORTS*DATA_WIDTH-1:0] write_data,
  input  logic [NUM_WRITE_PORTS-1:0]            write_enable,
  input  logic                                  alloc_valid,
  input  logic [IDX_W-1:0]                      alloc_addr,
  input  logic                                  flush,
  output logic [NUM_REGS-1:0]                   pending_vec
);

  function automatic logic f_is_zero(input logic [IDX_W-1:0] a);
    return (ZERO_REG_EN != 0) && (a == IDX_W'(REG_ZERO));
  endfunction

  logic [IDX_W-1:0]      w_wr_addr [NUM_WRITE_PORTS];
  logic [DATA_WIDTH-1:0] w_wr_data [NUM_WRITE_PORTS];
  logic [NUM_WRITE_PORTS-1:0] w_wr_en;
  logic [NUM_REGS-1:0]   w_wr_hit;

  logic [IDX_W-1:0]      w_rd_addr     [NUM_READ_PORTS];
  logic [DATA_WIDTH-1:0] w_rd_data_nxt [NUM_READ_PORTS];
  logic [NUM_READ_PORTS-1:0] w_rd_ready_nxt;

  logic [NUM_REGS-1:0]   w_pending;
  logic [NUM_REGS-1:0]   w_pending_nxt;

  logic [DATA_WIDTH-1:0] r_regs       [NUM_REGS];
  logic [DATA_WIDTH-1:0] r_rd_data_p1 [NUM_READ_PORTS];
  logic [NUM_READ_PORTS-1:0] r_rd_ready_p1;

  // Writes to the zero register are squashed here so storage, bypass and
  // scoreboard all see the same filtered enables.
  always_comb begin
    w_wr_hit = '0;
    for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
      w_wr_addr[p] = write_reg_addr[p*IDX_W +: IDX_W];
      w_wr_data[p] = write_data[p*DATA_WIDTH +: DATA_WIDTH];
      w_wr_en[p]   = write_enable[p] && !f_is_zero(w_wr_addr[p]);
      if (w_wr_en[p]) begin
        w_wr_hit[w_wr_addr[p]] = 1'b1;
      end
    end
  end

  // Ascending port order: the highest-numbered enabled port wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
        if (w_wr_en[p]) begin
          r_regs[w_wr_addr[p]] <= w_wr_data[p];
        end
      end
    end
  end

  rf_scoreboard_m #(
    .NUM_REGS    (NUM_REGS),
    .IDX_W       (IDX_W),
    .ZERO_REG_EN (ZERO_REG_EN)
  ) u_scoreboard (
    .clk           (clk),
    .reset         (reset),
    .i_alloc_valid (alloc_valid),
    .i_alloc_addr  (alloc_addr),
    .i_flush       (flush),
    .i_wr_hit      (w_wr_hit),
    .o_pending     (w_pending),
    .o_pending_nxt (w_pending_nxt)
  );

  // Read stage p0: storage lookup with same-cycle write bypass.
  always_comb begin
    for (int r = 0; r < NUM_READ_PORTS; r++) begin
      w_rd_addr[r]     = read_reg_addr[r*IDX_W +: IDX_W];
      w_rd_data_nxt[r] = r_regs[w_rd_addr[r]];
      for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
        if (w_wr_en[p] && (w_wr_addr[p] == w_rd_addr[r])) begin
          w_rd_data_nxt[r] = w_wr_data[p];
        end
      end
      if (f_is_zero(w_rd_addr[r])) begin
        w_rd_data_nxt[r] = DATA_WIDTH'(REG_ZERO_VAL);
      end
      w_rd_ready_nxt[r] = ~w_pending_nxt[w_rd_addr[r]];
    end
  end

  // Read stage p1: registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NUM_READ_PORTS; r++) begin
        r_rd_data_p1[r] <= '0;
      end
      r_rd_ready_p1 <= '1;
    end else begin
      for (int r = 0; r < NUM_READ_PORTS; r++) begin
        r_rd_data_p1[r] <= w_rd_data_nxt[r];
      end
      r_rd_ready_p1 <= w_rd_ready_nxt;
    end
  end

  for (genvar g = 0; g < NUM_READ_PORTS; g++) begin : g_rd_out
    assign read_data[g*DATA_WIDTH +: DATA_WIDTH] = r_rd_data_p1[g];
  end

  assign read_ready  = r_rd_ready_p1;
  assign pending_vec = w_pending;

endmodule

// File: tb/tb_mp_register_file_m.sv
// Directed bench for mp_register_file_m: a 2-read/2-write instance with the
// zero register and a 1-read/1-write instance without it.
module tb_mp_register_file_m;

  logic clk;
  logic reset;

  logic [9:0]  a_rd_addr;
  logic [63:0] a_rd_data;
  logic [1:0]  a_rd_ready;
  logic [9:0]  a_wr_addr;
  logic [63:0] a_wr_data;
  logic [1:0]  a_wr_en;
  logic        a_alloc_valid;
  logic [4:0]  a_alloc_addr;
  logic        a_flush;
  logic [31:0] a_pending;

  logic [4:0]  b_rd_addr;
  logic [31:0] b_rd_data;
  logic        b_rd_ready;
  logic [4:0]  b_wr_addr;
  logic [31:0] b_wr_data;
  logic        b_wr_en;
  logic        b_alloc_valid;
  logic [4:0]  b_alloc_addr;
  logic        b_flush;
  logic [31:0] b_pending;

  int n_cmp = 0;
  int n_err = 0;

  mp_register_file_m #(
    .DATA_WIDTH(32), .NUM_REGS(32), .NUM_READ_PORTS(2),
    .NUM_WRITE_PORTS(2), .ZERO_REG_EN(1)
  ) dut_a (
    .clk(clk), .reset(reset),
    .read_reg_addr(a_rd_addr), .read_data(a_rd_data), .read_ready(a_rd_ready),
    .write_reg_addr(a_wr_addr), .write_data(a_wr_data), .write_enable(a_wr_en),
    .alloc_valid(a_alloc_valid), .alloc_addr(a_alloc_addr),
    .flush(a_flush), .pending_vec(a_pending)
  );

  mp_register_file_m #(
    .DATA_WIDTH(32), .NUM_REGS(32), .NUM_READ_PORTS(1),
    .NUM_WRITE_PORTS(1), .ZERO_REG_EN(0)
  ) dut_b (
    .clk(clk), .reset(reset),
    .read_reg_addr(b_rd_addr), .read_data(b_rd_data), .read_ready(b_rd_ready),
    .write_reg_addr(b_wr_addr), .write_data(b_wr_data), .write_enable(b_wr_en),
    .alloc_valid(b_alloc_valid), .alloc_addr(b_alloc_addr),
    .flush(b_flush), .pending_vec(b_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    a_wr_en = 2'b00;
    a_alloc_valid = 1'b0;
    a_flush = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    a_rd_addr = '0; a_wr_addr = '0; a_wr_data = '0; a_wr_en = '0;
    a_alloc_valid = 1'b0; a_alloc_addr = '0; a_flush = 1'b0;
    b_rd_addr = '0; b_wr_addr = '0; b_wr_data = '0; b_wr_en = 1'b0;
    b_alloc_valid = 1'b0; b_alloc_addr = '0; b_flush = 1'b0;

    // 1: write during reset is lost
    a_wr_addr = {5'd0, 5'd5};
    a_wr_data = {32'h0, 32'hDEADBEEF};
    a_wr_en   = 2'b01;
    repeat (2) @(posedge clk);
    #1;
    check("rst_data", a_rd_data, 64'h0);
    check("rst_ready", {62'h0, a_rd_ready}, 64'h3);
    check("rst_pending", {32'h0, a_pending}, 64'h0);
    check("rst_b_ready", {63'h0, b_rd_ready}, 64'h1);
    reset = 1'b0;
    a_wr_en = 2'b00;
    a_rd_addr = {5'd5, 5'd5};
    step();
    check("t1_x5_data", {32'h0, a_rd_data[31:0]}, 64'h0);
    check("t1_ready", {62'h0, a_rd_ready}, 64'h3);
    check("t1_pending", {32'h0, a_pending}, 64'h0);

    // 2: bypass on both read ports, then storage read
    a_wr_addr = {5'd0, 5'd7};
    a_wr_data = {32'h0, 32'h12345678};
    a_wr_en   = 2'b01;
    a_rd_addr = {5'd7, 5'd7};
    step();
    check("t2_byp_p0", {32'h0, a_rd_data[31:0]}, 64'h12345678);
    check("t2_byp_p1", {32'h0, a_rd_data[63:32]}, 64'h12345678);
    idle_a();
    step();
    check("t2_stored", {32'h0, a_rd_data[31:0]}, 64'h12345678);

    // 3: two write ports to the same index, port1 wins
    a_wr_addr = {5'd3, 5'd3};
    a_wr_data = {32'h2222, 32'h1111};
    a_wr_en   = 2'b11;
    a_rd_addr = {5'd7, 5'd3};
    step();
    check("t3_byp_prio", {32'h0, a_rd_data[31:0]}, 64'h2222);
    idle_a();
    step();
    check("t3_stored_prio", {32'h0, a_rd_data[31:0]}, 64'h2222);
    check("t3_other_port", {32'h0, a_rd_data[63:32]}, 64'h12345678);

    // 4: alloc then writeback clears pending
    a_alloc_valid = 1'b1;
    a_alloc_addr  = 5'd9;
    a_rd_addr     = {5'd0, 5'd9};
    step();
    check("t4_alloc_ready", {63'h0, a_rd_ready[0]}, 64'h0);
    check("t4_alloc_pend", {32'h0, a_pending}, 64'h200);
    idle_a();
    step();
    check("t4_hold_ready", {63'h0, a_rd_ready[0]}, 64'h0);
    a_wr_addr = {5'd0, 5'd9};
    a_wr_data = {32'h0, 32'hAA};
    a_wr_en   = 2'b01;
    step();
    check("t4_wb_data", {32'h0, a_rd_data[31:0]}, 64'hAA);
    check("t4_wb_ready", {63'h0, a_rd_ready[0]}, 64'h1);
    check("t4_wb_pend", {32'h0, a_pending}, 64'h0);

    // 5: alloc beats same-cycle write; flush beats alloc
    idle_a();
    a_alloc_valid = 1'b1;
    a_alloc_addr  = 5'd4;
    a_wr_addr = {5'd4, 5'd0};
    a_wr_data = {32'h55, 32'h0};
    a_wr_en   = 2'b10;
    a_rd_addr = {5'd4, 5'd0};
    step();
    check("t5_pend4", {32'h0, a_pending}, 64'h10);
    check("t5_ready", {62'h0, a_rd_ready}, 64'h1);
    check("t5_data", {32'h0, a_rd_data[63:32]}, 64'h55);
    idle_a();
    a_flush = 1'b1;
    a_alloc_valid = 1'b1;
    a_alloc_addr  = 5'd6;
    a_rd_addr = {5'd4, 5'd6};
    step();
    check("t5_flush_pend", {32'h0, a_pending}, 64'h0);
    check("t5_flush_ready", {62'h0, a_rd_ready}, 64'h3);

    // 6: zero register on A, ordinary register on B
    idle_a();
    a_wr_addr = {5'd0, 5'd0};
    a_wr_data = {32'h0, 32'hFFFFFFFF};
    a_wr_en   = 2'b01;
    a_alloc_valid = 1'b1;
    a_alloc_addr  = 5'd0;
    a_rd_addr = {5'd0, 5'd0};
    b_wr_addr = 5'd0;
    b_wr_data = 32'hFFFFFFFF;
    b_wr_en   = 1'b1;
    b_alloc_valid = 1'b1;
    b_alloc_addr  = 5'd0;
    b_rd_addr = 5'd0;
    step();
    check("t6_x0_data", a_rd_data, 64'h0);
    check("t6_x0_ready", {62'h0, a_rd_ready}, 64'h3);
    check("t6_x0_pend", {32'h0, a_pending}, 64'h0);
    check("t6_b_data", {32'h0, b_rd_data}, 64'hFFFFFFFF);
    check("t6_b_ready", {63'h0, b_rd_ready}, 64'h0);
    check("t6_b_pend", {32'h0, b_pending}, 64'h1);
    idle_a();
    step();
    check("t6_x0_stored", a_rd_data, 64'h0);
    b_alloc_valid = 1'b0;
    b_wr_data = 32'h5;
    step();
    check("t6_b_wb_data", {32'h0, b_rd_data}, 64'h5);
    check("t6_b_wb_ready", {63'h0, b_rd_ready}, 64'h1);
    check("t6_b_wb_pend", {32'h0, b_pending}, 64'h0);
    b_wr_en = 1'b0;
    step();
    check("t6_b_stored", {32'h0, b_rd_data}, 64'h5);

    // mid-operation asynchronous reset
    a_alloc_valid = 1'b1;
    a_alloc_addr  = 5'd12;
    a_rd_addr = {5'd7, 5'd12};
    step();
    check("mr_pend_before", {32'h0, a_pending}, 64'h1000);
    idle_a();
    #2;
    reset = 1'b1;
    #1;
    check("mr_async_pend", {32'h0, a_pending}, 64'h0);
    check("mr_async_data", a_rd_data, 64'h0);
    check("mr_async_ready", {62'h0, a_rd_ready}, 64'h3);
    a_wr_addr = {5'd0, 5'd10};
    a_wr_data = {32'h0, 32'hCAFE};
    a_wr_en   = 2'b01;
    step();
    reset = 1'b0;
    a_wr_en = 2'b00;
    a_rd_addr = {5'd7, 5'd10};
    step();
    check("mr_lost_write", {32'h0, a_rd_data[31:0]}, 64'h0);
    check("mr_cleared_x7", {32'h0, a_rd_data[63:32]}, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
